logic_unit_arbiter: RTL and testbench

// - Shares one registered bitwise logic unit (AND/OR/NOT-A/XOR/XNOR/NAND) between NREQ requesters.
// - Each requester presents operands and an opcode with a valid/ready handshake.
// - Round-robin arbitration picks one requester; the block executes the operation and returns a tagged result.
// - Sits between the gate-level datapath and the client blocks that need bitwise operations.

---
 rtl/logic_unit_arbiter.sv | 140 ++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of one registered bitwise logic unit.
// One operation in flight: grant in IDLE, compute in CALC, hold the tagged result in RESP.
module logic_unit_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  res_err
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   rr_ptr_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [2:0]       op_reg;
  logic [IDW-1:0]   id_reg;
  logic             res_valid_reg;
  logic [WIDTH-1:0] res_data_reg;
  logic [IDW-1:0]   res_id_reg;
  logic             res_err_reg;

  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];
  logic [2:0]       op_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
      assign op_arr[gi] = req_op[gi*3 +: 3];
    end
  endgenerate

  // First pending requester at or above rr_ptr, wrapping modulo NREQ.
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] scan_idx;
  logic [IDW-1:0] rr_next;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr_reg) + k) % NREQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
    rr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  end

  always_comb begin
    req_ready = '0;
    if (state_reg == IDLE && grant_found && !rst)
      req_ready[grant_id] = 1'b1;
  end

  logic [WIDTH-1:0] calc_data;
  logic             calc_err;

  always_comb begin
    calc_data = '0;
    calc_err  = 1'b0;
    case (op_reg)
      3'd0:    calc_data = a_reg & b_reg;
      3'd1:    calc_data = a_reg | b_reg;
      3'd2:    calc_data = ~a_reg;
      3'd3:    calc_data = a_reg ^ b_reg;
      3'd4:    calc_data = ~(a_reg ^ b_reg);
      3'd5:    calc_data = ~(a_reg & b_reg);
      default: calc_err  = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = CALC;
      CALC:    state_next = RESP;
      RESP:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= '0;
      id_reg        <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_id_reg    <= '0;
      res_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            a_reg      <= a_arr[grant_id];
            b_reg      <= b_arr[grant_id];
            op_reg     <= op_arr[grant_id];
            id_reg     <= grant_id;
            rr_ptr_reg <= rr_next;
          end
        end
        CALC: begin
          res_data_reg  <= calc_data;
          res_err_reg   <= calc_err;
          res_id_reg    <= id_reg;
          res_valid_reg <= 1'b1;
        end
        RESP: if (res_ready) res_valid_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;
  assign res_err   = res_err_reg;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: opcode table, round-robin order,
// back-pressure hold and reset-in-flight sequences.
module tb_logic_unit_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*3-1:0]     req_op;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_data;
  logic [IDW-1:0]        res_id;
  logic                  res_err;

  logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_op[id*3 +: 3]        = op;
  endtask

  task automatic run_vec(input vec_t v);
    logic [NREQ-1:0] onehot;
    onehot = '0;
    onehot[v.id] = 1'b1;
    @(negedge clk);
    req_valid = onehot;
    set_req(v.id, v.a, v.b, v.op);
    #1;
    chk("grant_ready", 32'(req_ready), 32'(onehot));
    tick();
    req_valid = '0;
    chk("calc_res_valid", 32'(res_valid), 32'd0);
    chk("calc_req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("resp_valid", 32'(res_valid), 32'd1);
    chk("resp_data", 32'(res_data), 32'(v.exp_data));
    chk("resp_id", 32'(res_id), 32'(v.id));
    chk("resp_err", 32'(res_err), 32'(v.exp_err));
    tick();
    chk("done_valid", 32'(res_valid), 32'd0);
    $display("vec id=%0d a=%02h b=%02h op=%0d -> data=%02h err=%0d", v.id, v.a, v.b, v.op, res_data, res_err);
  endtask

  // Waits (bounded) until some requester is granted; leaves time at #1 after an edge.
  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic            ok;
    logic [WIDTH-1:0] held_data;

    vecs[0]  = '{1, 8'hF0, 8'h3C, 3'd3, 8'hCC, 1'b0};
    vecs[1]  = '{0, 8'hA5, 8'h0F, 3'd0, 8'h05, 1'b0};
    vecs[2]  = '{0, 8'hA5, 8'h0F, 3'd1, 8'hAF, 1'b0};
    vecs[3]  = '{0, 8'hA5, 8'h0F, 3'd2, 8'h5A, 1'b0};
    vecs[4]  = '{0, 8'hA5, 8'h0F, 3'd3, 8'hAA, 1'b0};
    vecs[5]  = '{0, 8'hA5, 8'h0F, 3'd4, 8'h55, 1'b0};
    vecs[6]  = '{0, 8'hA5, 8'h0F, 3'd5, 8'hFA, 1'b0};
    vecs[7]  = '{2, 8'hA5, 8'h0F, 3'd6, 8'h00, 1'b1};
    vecs[8]  = '{3, 8'h12, 8'h34, 3'd7, 8'h00, 1'b1};
    vecs[9]  = '{3, 8'hFF, 8'h00, 3'd2, 8'h00, 1'b0};
    vecs[10] = '{2, 8'hC3, 8'h81, 3'd4, 8'hBD, 1'b0};
    vecs[11] = '{1, 8'h00, 8'h00, 3'd5, 8'hFF, 1'b0};

    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    res_ready = 1'b1;

    // Reset with every requester pending: no grant may leak out.
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("rst_req_ready2", 32'(req_ready), 32'd0);
    tick();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    $display("reset done");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Round-robin from a fresh pointer with all four requesters held.
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h10 + 8'(i), 8'hFF, 3'd0);
    req_valid = '1;
    #1;
    for (int k = 0; k < 8; k++) begin
      logic [NREQ-1:0] exp_oh;
      exp_oh = '0;
      exp_oh[k % NREQ] = 1'b1;
      wait_grant(ok);
      chk("rr_grant", 32'(req_ready), 32'(exp_oh));
      tick();
      tick();
      chk("rr_valid", 32'(res_valid), 32'd1);
      chk("rr_id", 32'(res_id), 32'(k % NREQ));
      chk("rr_data", 32'(res_data), 32'(8'h10 + 8'(k % NREQ)));
      $display("rr op=%0d id=%0d data=%02h", k, res_id, res_data);
      tick();
    end
    req_valid = '0;

    // Back-pressure: result must hold while others are waiting, no new grants.
    @(negedge clk);
    res_ready = 1'b0;
    set_req(2, 8'hFF, 8'h3C, 3'd0);
    req_valid = 4'b0100;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1111;
    tick();
    chk("bp_valid", 32'(res_valid), 32'd1);
    held_data = res_data;
    chk("bp_data", 32'(res_data), 32'h3C);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_data", 32'(res_data), 32'(held_data));
      chk("bp_hold_id", 32'(res_id), 32'd2);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    chk("bp_release", 32'(res_valid), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'h8);
    req_valid = '0;
    $display("backpressure id=2 data=%02h", held_data);

    // Reset while in CALC discards the operation and rewinds the pointer.
    @(negedge clk);
    set_req(1, 8'hAA, 8'h55, 3'd1);
    req_valid = 4'b0010;
    #1;
    chk("rc_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    chk("rc_ready_in_rst", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rc_res_valid", 32'(res_valid), 32'd0);
    chk("rc_res_data", 32'(res_data), 32'd0);
    chk("rc_ptr_zero", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();
    tick();
    chk("rc_idle_quiet", 32'(res_valid), 32'd0);
    $display("reset-in-calc done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
